calc_seq_ctrl: RTL and testbench
================================

Name: calc_seq_ctrl

Overview:
Sequencing controller for the keypad single-digit adder path. It debounces the load, sum and clear push-buttons and steps a four-state FSM: capture operand A, capture operand B, show A+B. It holds the operand and result registers and drives BCD digit and blank controls to the seven-segment scanner, so the top level only instantiates it plus the display driver.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive sys_clk cycles a synchronised button must differ from its debounced level before that level flips (>=2)
DIGIT_W, 4, keypad/operand width; keys 0..9 valid

Ports:
sys_clk  in  1  system clock, all logic on rising edge
sys_rst  in  1  synchronous, active-high reset
load_button  in  1  raw, bouncy, asynchronous
sum_button  in  1  raw, bouncy, asynchronous
clr_button  in  1  raw, bouncy, asynchronous
key_pad  in  DIGIT_W  keypad digit, quasi-static, sampled on load pulse
state  out  2  FSM state code
disp_left  out  4  BCD digit, left display
disp_right  out  4  BCD digit, right display
blank_left  out  1  1 = left digit dark
blank_right  out  1  1 = right digit dark
key_err  out  1  one-cycle pulse: load with key_pad > 9

Behaviour:
- Reset is synchronous and active-high; one clock, sys_clk. While sys_rst=1 at an edge: state=IDLE, op_a=op_b=0, sum_reg=0, sync and debounce flops=0, counters=0, disp_left=disp_right=0, blank_left=blank_right=1, key_err=0. Mid-operation reset discards captured operands; no pulse is produced for a button still held after release of reset until it is released and pressed again.
- Per button: 2-flop synchroniser -> counter. Counter clears when sync==deb, else increments. When sync!=deb and count==DEBOUNCE_CYCLES-1, deb<=sync and counter clears. Pulse = deb & ~deb_q, exactly one cycle per press. Glitches shorter than DEBOUNCE_CYCLES cycles produce no pulse. Release is debounced the same way and produces no pulse.
- Latency: a button held stable from edge n gives a pulse during cycle n+2+DEBOUNCE_CYCLES. State and display change at the following edge.
- FSM states: IDLE=0, HAVE_A=1, HAVE_B=2, SHOW=3. Priority when pulses coincide: clr > sum > load.
  - clr_p in any state -> IDLE. Operands and sum are cleared.
  - IDLE + load_p with valid key -> op_a<=key, HAVE_A.
  - HAVE_A + load_p with valid key -> op_b<=key, HAVE_B.
  - HAVE_B + sum_p -> sum_reg<=op_a+op_b (5-bit, max 18), SHOW.
  - SHOW + load_p with valid key -> op_a<=key, op_b<=0, HAVE_A. This starts a new calculation.
  - HAVE_B + load_p is ignored; B is not overwritten.
  - sum_p in IDLE, HAVE_A or SHOW is ignored.
  - load_p with key_pad>9 causes no state or operand change and pulses key_err for 1 cycle, in any state except when clr_p coincides.
- Display, registered and updated with state:
  - IDLE: both digits blank.
  - HAVE_A: left blank, right=op_a.
  - HAVE_B: left=op_a, right=op_b.
  - SHOW: left=sum_reg/10, right=sum_reg%10. Left is blank when sum<10.
- Blanked digit values are driven 0.

Decomposition:
- Package calc_pkg holds the state encodings (IDLE, HAVE_A, HAVE_B, SHOW), MAX_DIGIT=9 and SUM_W=5.
- One sub-module, btn_debounce (param DEBOUNCE_CYCLES; ports sys_clk, sys_rst, btn_raw, btn_pulse), instantiated three times.
- The BCD split is a small combinational case on 0..18 inside calc_seq_ctrl.

Test Plan:
1. Reset; key=7, load bounced 4x within 1 cycle then held 8 cycles -> exactly one pulse, state=HAVE_A, right=7, left blank; no second pulse on bounced release.
2. From HAVE_A: key=5, load; then sum -> HAVE_B shows left 7, right 5; SHOW shows left 1, right 2 (12); key=9+9 sequence gives 1/8; key=2+3 gives left blank, right 5.
3. Sum pressed in IDLE and in HAVE_A -> no change. Load in HAVE_B with key=4 -> op_b stays 5.
4. key=12, load in IDLE -> key_err high for exactly 1 cycle, state stays IDLE, displays stay blank.
5. clr and sum debounced so their pulses land in the same cycle while in HAVE_B -> IDLE, both displays blank. Load pulse alone in SHOW with key=3 -> HAVE_A, right=3.
6. sys_rst asserted mid-debounce with load held in HAVE_B -> IDLE on the next edge, no pulse while load stays held; pulse only after release and a re-press.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types and constants for the keypad single-digit adder controller.
package calc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HAVE_A = 2'd1,
        HAVE_B = 2'd2,
        SHOW   = 2'd3
    } state_t;

    localparam int MAX_DIGIT = 9;
    localparam int SUM_W     = 5;

endpackage

// File: rtl/calc_seq_ctrl_if.sv
// Button, keypad and display-control bundle between the controller and its environment.
interface calc_seq_ctrl_if #(
    parameter int DIGIT_W = 4
);
    logic               load_button;
    logic               sum_button;
    logic               clr_button;
    logic [DIGIT_W-1:0] key_pad;
    logic [1:0]         state;
    logic [3:0]         disp_left;
    logic [3:0]         disp_right;
    logic               blank_left;
    logic               blank_right;
    logic               key_err;

    modport master (
        output load_button, sum_button, clr_button, key_pad,
        input  state, disp_left, disp_right, blank_left, blank_right, key_err
    );

    modport slave (
        input  load_button, sum_button, clr_button, key_pad,
        output state, disp_left, disp_right, blank_left, blank_right, key_err
    );
endinterface

// File: rtl/btn_debounce.sv
// Push-button synchroniser + debouncer; emits a one-cycle pulse per debounced press.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic btn_raw,
    output logic btn_pulse
);
    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       r_sync;
    logic [1:0]       r_vld;
    logic             r_deb;
    logic             r_deb_q;
    logic             r_armed;
    logic [CNT_W-1:0] r_cnt;
    logic             w_sync;

    assign w_sync = r_sync[1];

    // r_armed only rises once a genuine released level has crossed the synchroniser,
    // so a button held through reset cannot produce a press pulse.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_sync  <= '0;
            r_vld   <= '0;
            r_deb   <= 1'b0;
            r_deb_q <= 1'b0;
            r_armed <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync  <= {r_sync[0], btn_raw};
            r_vld   <= {r_vld[0], 1'b1};
            r_deb_q <= r_deb;
            if (r_vld[1] && !w_sync) begin
                r_armed <= 1'b1;
            end
            if (w_sync == r_deb) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_deb <= w_sync;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign btn_pulse = r_deb & ~r_deb_q & r_armed;

endmodule

// File: rtl/calc_seq_ctrl.sv
// Operand capture / sum sequencing FSM with registered BCD display controls.
module calc_seq_ctrl
    import calc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DIGIT_W         = 4
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    calc_seq_ctrl_if.slave  bus
);
    logic w_load_p, w_sum_p, w_clr_p, w_key_ok;

    state_t             r_state, w_state_nxt;
    logic [DIGIT_W-1:0] r_op_a, r_op_b, w_op_a_nxt, w_op_b_nxt;
    logic [SUM_W-1:0]   r_sum, w_sum_nxt;
    logic [3:0]         r_disp_left, r_disp_right, w_disp_left_nxt, w_disp_right_nxt;
    logic               r_blank_left, r_blank_right, w_blank_left_nxt, w_blank_right_nxt;
    logic               r_key_err, w_key_err_nxt;
    logic [3:0]         w_tens, w_ones;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load_db (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .btn_raw(bus.load_button), .btn_pulse(w_load_p)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sum_db (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .btn_raw(bus.sum_button), .btn_pulse(w_sum_p)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr_db (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .btn_raw(bus.clr_button), .btn_pulse(w_clr_p)
    );

    assign w_key_ok = (bus.key_pad <= DIGIT_W'(MAX_DIGIT));

    always_comb begin
        w_state_nxt   = r_state;
        w_op_a_nxt    = r_op_a;
        w_op_b_nxt    = r_op_b;
        w_sum_nxt     = r_sum;
        w_key_err_nxt = w_load_p & ~w_key_ok & ~w_clr_p;
        if (w_clr_p) begin
            w_state_nxt = IDLE;
            w_op_a_nxt  = '0;
            w_op_b_nxt  = '0;
            w_sum_nxt   = '0;
        end else if (w_sum_p && r_state == HAVE_B) begin
            w_sum_nxt   = SUM_W'(r_op_a) + SUM_W'(r_op_b);
            w_state_nxt = SHOW;
        end else if (w_load_p && w_key_ok) begin
            case (r_state)
                IDLE: begin
                    w_op_a_nxt  = bus.key_pad;
                    w_state_nxt = HAVE_A;
                end
                HAVE_A: begin
                    w_op_b_nxt  = bus.key_pad;
                    w_state_nxt = HAVE_B;
                end
                SHOW: begin
                    w_op_a_nxt  = bus.key_pad;
                    w_op_b_nxt  = '0;
                    w_state_nxt = HAVE_A;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_tens = '0;
        w_ones = '0;
        case (w_sum_nxt) inside
            [5'd0:5'd9]:   w_ones = 4'(w_sum_nxt);
            [5'd10:5'd18]: begin
                w_tens = 4'd1;
                w_ones = 4'(w_sum_nxt - SUM_W'(10));
            end
            default: ;
        endcase
    end

    // Display is derived from the next-state values so it changes on the same edge as state.
    always_comb begin
        w_disp_left_nxt   = '0;
        w_disp_right_nxt  = '0;
        w_blank_left_nxt  = 1'b1;
        w_blank_right_nxt = 1'b1;
        case (w_state_nxt)
            HAVE_A: begin
                w_blank_right_nxt = 1'b0;
                w_disp_right_nxt  = 4'(w_op_a_nxt);
            end
            HAVE_B: begin
                w_blank_left_nxt  = 1'b0;
                w_blank_right_nxt = 1'b0;
                w_disp_left_nxt   = 4'(w_op_a_nxt);
                w_disp_right_nxt  = 4'(w_op_b_nxt);
            end
            SHOW: begin
                w_blank_left_nxt  = (w_tens == 4'd0);
                w_blank_right_nxt = 1'b0;
                w_disp_left_nxt   = w_tens;
                w_disp_right_nxt  = w_ones;
            end
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state       <= IDLE;
            r_op_a        <= '0;
            r_op_b        <= '0;
            r_sum         <= '0;
            r_disp_left   <= '0;
            r_disp_right  <= '0;
            r_blank_left  <= 1'b1;
            r_blank_right <= 1'b1;
            r_key_err     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_op_a        <= w_op_a_nxt;
            r_op_b        <= w_op_b_nxt;
            r_sum         <= w_sum_nxt;
            r_disp_left   <= w_disp_left_nxt;
            r_disp_right  <= w_disp_right_nxt;
            r_blank_left  <= w_blank_left_nxt;
            r_blank_right <= w_blank_right_nxt;
            r_key_err     <= w_key_err_nxt;
        end
    end

    assign bus.state       = r_state;
    assign bus.disp_left   = r_disp_left;
    assign bus.disp_right  = r_disp_right;
    assign bus.blank_left  = r_blank_left;
    assign bus.blank_right = r_blank_right;
    assign bus.key_err     = r_key_err;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Bench for calc_seq_ctrl: behavioural model compared every cycle plus directed literal checks.
module tb_calc_seq_ctrl;
    localparam int DC = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    calc_seq_ctrl_if #(.DIGIT_W(4)) bus ();

    calc_seq_ctrl #(.DEBOUNCE_CYCLES(DC), .DIGIT_W(4)) dut (
        .sys_clk(clk),
        .sys_rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Buttons: 0=load 1=sum 2=clr. A press registers once the synchronised level has
    // disagreed with the settled level for DC consecutive edges; it acts one edge later.
    bit m_started = 0;
    bit m_r1[3], m_r2[3], m_v1[3], m_v2[3], m_deb[3], m_armed[3], m_pend[3];
    int m_run[3];
    int m_npulse[3];
    int m_state, m_a, m_b, m_s;
    bit m_kerr;

    always @(posedge clk) begin
        bit raw[3];
        bit ld, sm, cl, syn, sv;
        int key;
        raw[0] = bus.load_button;
        raw[1] = bus.sum_button;
        raw[2] = bus.clr_button;
        key = int'(bus.key_pad);
        m_started = 1;
        if (rst) begin
            for (int b = 0; b < 3; b++) begin
                m_r1[b] = 0; m_r2[b] = 0; m_v1[b] = 0; m_v2[b] = 0;
                m_deb[b] = 0; m_armed[b] = 0; m_pend[b] = 0; m_run[b] = 0;
            end
            m_state = 0; m_a = 0; m_b = 0; m_s = 0; m_kerr = 0;
        end else begin
            ld = m_pend[0]; sm = m_pend[1]; cl = m_pend[2];
            m_kerr = ld && (key > 9) && !cl;
            if (cl) begin
                m_state = 0; m_a = 0; m_b = 0; m_s = 0;
            end else if (sm && m_state == 2) begin
                m_s = m_a + m_b; m_state = 3;
            end else if (ld && key <= 9) begin
                if (m_state == 0)      begin m_a = key; m_state = 1; end
                else if (m_state == 1) begin m_b = key; m_state = 2; end
                else if (m_state == 3) begin m_a = key; m_b = 0; m_state = 1; end
            end
            for (int b = 0; b < 3; b++) begin
                syn = m_r2[b]; sv = m_v2[b];
                m_r2[b] = m_r1[b]; m_v2[b] = m_v1[b];
                m_r1[b] = raw[b];  m_v1[b] = 1;
                if (sv && !syn) m_armed[b] = 1;
                m_pend[b] = 0;
                if (syn != m_deb[b]) begin
                    m_run[b]++;
                    if (m_run[b] == DC) begin
                        m_deb[b] = syn;
                        m_run[b] = 0;
                        if (syn && m_armed[b]) begin
                            m_pend[b] = 1;
                            m_npulse[b]++;
                        end
                    end
                end else begin
                    m_run[b] = 0;
                end
            end
        end
    end

    int dut_kerr_cnt = 0;

    always @(negedge clk) begin
        int el, er, ebl, ebr;
        if (m_started) begin
            el = 0; er = 0; ebl = 1; ebr = 1;
            case (m_state)
                1: begin ebr = 0; er = m_a; end
                2: begin ebl = 0; ebr = 0; el = m_a; er = m_b; end
                3: begin ebr = 0; el = m_s / 10; er = m_s % 10; ebl = (m_s < 10); end
                default: ;
            endcase
            check("state",       int'(bus.state),       m_state);
            check("disp_left",   int'(bus.disp_left),   el);
            check("disp_right",  int'(bus.disp_right),  er);
            check("blank_left",  int'(bus.blank_left),  ebl);
            check("blank_right", int'(bus.blank_right), ebr);
            check("key_err",     int'(bus.key_err),     int'(m_kerr));
            if (bus.key_err) dut_kerr_cnt++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_btn(input int b, input bit v);
        case (b)
            0: bus.load_button = v;
            1: bus.sum_button  = v;
            default: bus.clr_button = v;
        endcase
    endtask

    task automatic press(input int b, input int hold);
        set_btn(b, 1'b1);
        tick(hold);
        set_btn(b, 1'b0);
        tick(DC + 6);
    endtask

    task automatic load_key(input int k);
        bus.key_pad = 4'(k);
        press(0, 8);
    endtask

    task automatic lit_disp(input string tag, input int st, input int bl, input int l,
                            input int br, input int r);
        check({tag, ".state"}, int'(bus.state), st);
        check({tag, ".blank_left"}, int'(bus.blank_left), bl);
        check({tag, ".disp_left"}, int'(bus.disp_left), l);
        check({tag, ".blank_right"}, int'(bus.blank_right), br);
        check({tag, ".disp_right"}, int'(bus.disp_right), r);
    endtask

    initial begin
        int kbefore, pbefore;
        bus.load_button = 0; bus.sum_button = 0; bus.clr_button = 0; bus.key_pad = '0;
        rst = 1;
        tick(3);
        lit_disp("reset", 0, 1, 0, 1, 0);
        check("reset.key_err", int'(bus.key_err), 0);
        rst = 0;
        tick(4);

        // 1: bouncy press and bouncy release of load with key 7
        bus.key_pad = 4'd7;
        pbefore = m_npulse[0];
        bus.load_button = 1; #1 bus.load_button = 0; #1 bus.load_button = 1;
        #1 bus.load_button = 0; #1 bus.load_button = 1;
        tick(8);
        bus.load_button = 0; #1 bus.load_button = 1; #1 bus.load_button = 0;
        #1 bus.load_button = 1; #1 bus.load_button = 0;
        tick(14);
        lit_disp("t1", 1, 1, 0, 0, 7);
        check("t1.model_pulses", m_npulse[0] - pbefore, 1);

        // 2: 7+5=12, then 9+9=18, then 2+3=5
        load_key(5);
        lit_disp("t2_hb", 2, 0, 7, 0, 5);
        press(1, 8);
        lit_disp("t2_12", 3, 0, 1, 0, 2);
        load_key(9);
        lit_disp("t2_newa", 1, 1, 0, 0, 9);
        load_key(9);
        press(1, 8);
        lit_disp("t2_18", 3, 0, 1, 0, 8);
        load_key(2);
        load_key(3);
        press(1, 8);
        lit_disp("t2_5", 3, 1, 0, 0, 5);

        // 3: ignored sums and ignored load in HAVE_B
        press(2, 8);
        press(1, 8);
        lit_disp("t3_idle_sum", 0, 1, 0, 1, 0);
        load_key(7);
        press(1, 8);
        lit_disp("t3_hava_sum", 1, 1, 0, 0, 7);
        load_key(5);
        load_key(4);
        lit_disp("t3_hb_load", 2, 0, 7, 0, 5);

        // 4: short glitch ignored, then invalid key
        press(2, 8);
        bus.key_pad = 4'd3;
        press(0, 2);
        lit_disp("t4_glitch", 0, 1, 0, 1, 0);
        kbefore = dut_kerr_cnt;
        load_key(12);
        check("t4.key_err_cycles", dut_kerr_cnt - kbefore, 1);
        lit_disp("t4_bad_key", 0, 1, 0, 1, 0);

        // 5: clr and sum coincide in HAVE_B; load alone in SHOW
        load_key(7);
        load_key(5);
        bus.clr_button = 1; bus.sum_button = 1;
        tick(8);
        bus.clr_button = 0; bus.sum_button = 0;
        tick(DC + 6);
        lit_disp("t5_clr_sum", 0, 1, 0, 1, 0);
        load_key(7);
        load_key(5);
        press(1, 8);
        load_key(3);
        lit_disp("t5_show_load", 1, 1, 0, 0, 3);

        // 6: reset while load is held in HAVE_B
        load_key(1);
        lit_disp("t6_hb", 2, 0, 3, 0, 1);
        bus.key_pad = 4'd4;
        bus.load_button = 1;
        tick(3);
        rst = 1;
        tick(1);
        rst = 0;
        tick(20);
        lit_disp("t6_held", 0, 1, 0, 1, 0);
        bus.load_button = 0;
        tick(DC + 6);
        lit_disp("t6_released", 0, 1, 0, 1, 0);
        load_key(4);
        lit_disp("t6_repress", 1, 1, 0, 0, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
